alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Sequential execute-stage ALU that consumes the 4-bit `Ctrl` code produced by the ALU control decoder and operates on two 32-bit operands. Logical, arithmetic, shift, compare and branch-condition operations complete in one cycle. `mul` runs as an iterative 32-step shift-add that holds the pipeline through `Busy`. The block sits in EX, between the ID/EX register and the EX/MEM register.

## Interface
- No parameters; data width fixed at 32, `Ctrl` width fixed at 4.
- `Clk` in 1 — single clock; all state changes on its rising edge.
- `Reset_n` in 1 — asynchronous, active-low reset.
- `Start` in 1 — request; sampled only in IDLE.
- `Ctrl` in 4 — operation code; sampled with `Start`.
- `A` in 32 — operand A / shift source / branch operand (rs); sampled with `Start`.
- `B` in 32 — operand B; for shifts, `B[4:0]` is the shift amount.
- `Cancel` in 1 — synchronous abort of an in-flight `mul`.
- `Result` out 32 — registered result; holds until the next completion.
- `Zero` out 1 — registered flag (see Operation); holds until the next completion.
- `Done` out 1 — one-cycle pulse on completion.
- `Busy` out 1 — high while a `mul` is iterating.

## Operation
- **Ctrl encoding:**
  - 0000 add, 0001 sub, 0010 mul, 0011 and
  - 0100 or, 0101 nor, 0110 xor
  - 0111 sll (`A << B[4:0]`), 1000 srl (logical `A >> B[4:0]`)
  - 1001 slt (signed; `Result` = 1 or 0)
  - 1010 ne, 1011 bgez, 1100 bgtz, 1101 blez, 1110 bltz
  - 1111 reserved
- **Arithmetic:** add, sub and mul wrap modulo 2^32, with no overflow trap.
  - mul returns the low 32 bits of A×B; signedness is irrelevant for the low half, so the unsigned shift-add is used.
- **Zero flag:**
  - For codes 0000–1001, `Zero` = (`Result` == 0). beq uses sub.
  - For branch codes 1010–1110, `Result` = 0 and `Zero` = branch condition:
    - ne: A≠B
    - bgez: A≥0 (signed)
    - bgtz: A>0
    - blez: A≤0
    - bltz: A<0
- **Reserved code 1111:** `Result` = 0, `Zero` = 0, `Done` still pulses.
- **FSM states:** IDLE, MUL.
  - **IDLE & Start & Ctrl≠0010:** compute, register `Result`/`Zero`, pulse `Done`; stay in IDLE.
  - **IDLE & Start & Ctrl=0010:** latch the multiplicand (A) and multiplier (B), clear the accumulator and 5-bit counter, `Busy`←1, go to MUL.
  - **MUL, each cycle:**
    - If multiplier[0] is set, add the multiplicand to the accumulator.
    - Shift the multiplicand left by 1 and the multiplier right by 1.
    - Increment the counter.
    - On the step where the counter = 31: register the final sum into `Result`, set `Zero`, pulse `Done`, `Busy`←0, go to IDLE.
  - **MUL & Cancel:** go to IDLE and clear `Busy`. `Result`, `Zero` and `Done` are unchanged (no pulse). `Cancel` in IDLE has no effect.
- **Start while Busy:** ignored; it is not queued.
- **Operand stability:** A, B and Ctrl changes during MUL have no effect, because the operands are latched.

## Timing
- **Reset values:** `Result`=0, `Zero`=0, `Done`=0, `Busy`=0; state IDLE; counter and accumulator cleared.
- **Reset mid-mul:** immediate abort to the reset values, regardless of `Clk`.
- **Single-cycle ops:** `Start` sampled at edge N → `Result`/`Zero` valid and `Done`=1 after edge N. `Done` falls after N+1 unless a new `Start` is sampled at N+1.
  - Back-to-back single-cycle ops are allowed every cycle, so `Done` stays high for consecutive completions.
- **mul:**
  - `Start` sampled at edge N → `Busy`=1 after N.
  - 32 iteration edges: N+1 … N+32.
  - `Result`, `Done`=1 and `Busy`=0 after N+32.
  - Earliest next `Start` is sampled at N+33.
- **Cancel and Start together in MUL:** `Cancel` wins; `Start` is ignored.

## Test plan
- **Wrapping add, then sub:** add A=0xFFFFFFFF, B=1 → after 1 edge `Result`=0, `Zero`=1, `Done` pulse. Then sub A=5, B=5 → `Zero`=1.
- **Shifts and signed compare:**
  - sll A=1, B=31 → 0x80000000.
  - srl A=0x80000000, B=31 → 1.
  - slt A=0xFFFFFFFF, B=1 → 1.
  - nor A=0, B=0 → 0xFFFFFFFF.
- **Branch codes:**
  - bltz A=0x80000000 → `Zero`=1, `Result`=0.
  - bgtz A=0 → `Zero`=0.
  - blez A=0 → 1.
  - ne A=3, B=4 → 1.
  - Code 1111 → `Result`=0, `Zero`=0, `Done` pulse.
- **mul latency and value:**
  - A=0xFFFFFFFD (−3), B=7 → `Busy` for exactly 32 cycles; `Done` after N+32 with `Result`=0xFFFFFFEB.
  - A=0x00010000, B=0x00010000 → `Result`=0, `Zero`=1.
- **Start during Busy:** add (Ctrl=0000) A=1, B=1 issued mid-mul → ignored; only the mul `Done` appears; `Result` = the product.
- **Abort paths:**
  - `Cancel` at iteration 10 → IDLE next cycle, no `Done`, `Result` retains its prior value.
  - `Reset_n` low mid-mul, asynchronously → all outputs 0 immediately.
  - A fresh add after the abort completes in 1 cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Execute-stage ALU. Single-cycle logical, arithmetic, shift,
//             compare and branch-condition operations, plus a 32-step
//             iterative shift-add multiply that holds the pipeline via Busy.
//  Ports    : Clk, Reset_n (async, active-low)
//             Start/Ctrl/A/B - request, sampled only while idle
//             Cancel         - aborts an in-flight multiply
//             Result/Zero    - registered, hold until the next completion
//             Done           - one-cycle completion pulse
//             Busy           - high while a multiply iterates
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [3:0]  Ctrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        Done,
    output logic        Busy
);

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_MUL  = 4'b0010;
    localparam logic [3:0] C_AND  = 4'b0011;
    localparam logic [3:0] C_OR   = 4'b0100;
    localparam logic [3:0] C_NOR  = 4'b0101;
    localparam logic [3:0] C_XOR  = 4'b0110;
    localparam logic [3:0] C_SLL  = 4'b0111;
    localparam logic [3:0] C_SRL  = 4'b1000;
    localparam logic [3:0] C_SLT  = 4'b1001;
    localparam logic [3:0] C_NE   = 4'b1010;
    localparam logic [3:0] C_BGEZ = 4'b1011;
    localparam logic [3:0] C_BGTZ = 4'b1100;
    localparam logic [3:0] C_BLEZ = 4'b1101;
    localparam logic [3:0] C_BLTZ = 4'b1110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;

    logic [31:0] w_result;
    logic        w_zero;
    logic [31:0] w_acc_next;

    // Single-cycle datapath, evaluated directly on the request operands.
    always_comb begin
        w_result = '0;
        w_zero   = 1'b0;
        case (Ctrl)
            C_ADD:   w_result = A + B;
            C_SUB:   w_result = A - B;
            C_AND:   w_result = A & B;
            C_OR:    w_result = A | B;
            C_NOR:   w_result = ~(A | B);
            C_XOR:   w_result = A ^ B;
            C_SLL:   w_result = A << B[4:0];
            C_SRL:   w_result = A >> B[4:0];
            C_SLT:   w_result = {31'd0, ($signed(A) < $signed(B))};
            C_NE:    w_zero   = (A != B);
            C_BGEZ:  w_zero   = ~A[31];
            C_BGTZ:  w_zero   = ~A[31] & (|A);
            C_BLEZ:  w_zero   = A[31] | ~(|A);
            C_BLTZ:  w_zero   = A[31];
            default: begin
                // mul is handled by the iterative path; 1111 is reserved
                // and reports Result=0, Zero=0.
                w_result = '0;
                w_zero   = 1'b0;
            end
        endcase
        // Non-branch codes report Result==0 on Zero.
        if (Ctrl <= C_SLT) begin
            w_zero = (w_result == 32'd0);
        end
    end

    // One shift-add step: accumulate the multiplicand when the current
    // multiplier LSB is set.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 32'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            Result   <= '0;
            Zero     <= 1'b0;
            Done     <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        if (Ctrl == C_MUL) begin
                            r_mcand  <= A;
                            r_mplier <= B;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            Busy     <= 1'b1;
                            r_state  <= S_MUL;
                        end else begin
                            Result <= w_result;
                            Zero   <= w_zero;
                            Done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    // Cancel outranks both the iteration and any Start.
                    if (Cancel) begin
                        Busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            Result  <= w_acc_next;
                            Zero    <= (w_acc_next == 32'd0);
                            Done    <= 1'b1;
                            Busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit. Stimulus pushes the
//             expected {Result, Zero} of every request that must complete;
//             a monitor pops and compares on each Done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [3:0]  Ctrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic [31:0] Result;
    logic        Zero;
    logic        Done;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];

    alu_exec_unit dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .Ctrl    (Ctrl),
        .A       (A),
        .B       (B),
        .Cancel  (Cancel),
        .Result  (Result),
        .Zero    (Zero),
        .Done    (Done),
        .Busy    (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Reset_n && Done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got Done=1 Result=%h Zero=%b, required no completion",
                         Result, Zero);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({Result, Zero} !== e) begin
                    errors++;
                    $display("FAIL completion: got Result=%h Zero=%b, required Result=%h Zero=%b",
                             Result, Zero, e[32:1], e[0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Present a request for one edge; optionally register its expected outcome.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input bit expect_done);
        Start = 1'b1;
        Ctrl  = c;
        A     = a;
        B     = b;
        if (expect_done) exp_q.push_back({er, ez});
        @(posedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (Busy && n < 50) begin
            @(posedge Clk);
            #1;
            n++;
        end
        if (Busy) check(name, 32'(Busy), 32'd0);
    endtask

    initial begin
        int n;
        Reset_n = 1'b0;
        Start   = 1'b0;
        Ctrl    = '0;
        A       = '0;
        B       = '0;
        Cancel  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_result", Result, 32'd0);
        check("reset_zero",   32'(Zero), 32'd0);
        check("reset_done",   32'(Done), 32'd0);
        check("reset_busy",   32'(Busy), 32'd0);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Single-cycle ops, back to back (Start held high across them).
        issue(4'b0000, 32'hFFFF_FFFF, 32'd1,          32'd0,          1'b1, 1);
        issue(4'b0001, 32'd5,         32'd5,          32'd0,          1'b1, 1);
        issue(4'b0111, 32'd1,         32'd31,         32'h8000_0000,  1'b0, 1);
        issue(4'b1000, 32'h8000_0000, 32'd31,         32'd1,          1'b0, 1);
        issue(4'b1001, 32'hFFFF_FFFF, 32'd1,          32'd1,          1'b0, 1);
        issue(4'b0101, 32'd0,         32'd0,          32'hFFFF_FFFF,  1'b0, 1);
        issue(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000,  1'b0, 1);
        issue(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hFFF0_FFF0,  1'b0, 1);
        issue(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0, 1);
        issue(4'b1110, 32'h8000_0000, 32'd0,          32'd0,          1'b1, 1);
        issue(4'b1100, 32'd0,         32'd0,          32'd0,          1'b0, 1);
        issue(4'b1101, 32'd0,         32'd0,          32'd0,          1'b1, 1);
        issue(4'b1010, 32'd3,         32'd4,          32'd0,          1'b1, 1);
        issue(4'b1011, 32'h7FFF_FFFF, 32'd0,          32'd0,          1'b1, 1);
        issue(4'b1111, 32'h1234_5678, 32'h1234_5678,  32'd0,          1'b0, 1);
        @(posedge Clk);
        #1;
        check("done_falls", 32'(Done), 32'd0);

        // mul -3 * 7: Busy for exactly 32 cycles, operands latched.
        issue(4'b0010, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1);
        check("mul_busy_start", 32'(Busy), 32'd1);
        A = '0;
        B = '0;
        n = 0;
        while (Busy && n < 40) begin
            @(posedge Clk);
            #1;
            n++;
        end
        check("mul_busy_cycles", n, 32'd32);
        check("mul_result", Result, 32'hFFFF_FFEB);

        // mul wrapping to zero.
        issue(4'b0010, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1);
        wait_idle("mul_wrap_timeout");
        @(posedge Clk);
        #1;

        // Start during Busy is ignored; only the mul completes.
        issue(4'b0010, 32'd6, 32'd7, 32'd42, 1'b0, 1);
        repeat (3) @(posedge Clk);
        #1;
        issue(4'b0000, 32'd1, 32'd1, 32'd0, 1'b0, 0);
        wait_idle("mul_ignore_timeout");
        check("mul_ignore_result", Result, 32'd42);
        @(posedge Clk);
        #1;

        // Cancel sampled at the tenth iteration edge.
        issue(4'b0010, 32'd3, 32'd5, 32'd0, 1'b0, 0);
        repeat (9) @(posedge Clk);
        #1;
        Cancel = 1'b1;
        Start  = 1'b1;
        Ctrl   = 4'b0000;
        @(posedge Clk);
        #1;
        Cancel = 1'b0;
        Start  = 1'b0;
        check("cancel_busy",   32'(Busy), 32'd0);
        check("cancel_result", Result, 32'd42);
        repeat (40) @(posedge Clk);
        #1;
        check("cancel_no_done_busy", 32'(Busy), 32'd0);
        check("cancel_hold_result", Result, 32'd42);

        // Asynchronous reset mid-mul.
        issue(4'b0010, 32'd9, 32'd9, 32'd0, 1'b0, 0);
        repeat (5) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("areset_result", Result, 32'd0);
        check("areset_busy",   32'(Busy), 32'd0);
        check("areset_done",   32'(Done), 32'd0);
        #3;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Fresh add completes in one cycle.
        issue(4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1);
        check("post_abort_done",   32'(Done), 32'd1);
        check("post_abort_result", Result, 32'd5);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge Clk);
            n++;
        end
        @(posedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding completions, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
